mpmc11_fifo_issue: RTL



---
 rtl/mpmc11_fifo_issue_if.sv | 32 +++
 rtl/mpmc11_fifo_issue.sv | 104 ++++++++++
 2 files changed

// File: rtl/mpmc11_fifo_issue_if.sv
// mpmc11 FIFO-issue bundle: FIFO read side and arbiter request side.
// master = issue block; slave = FIFO, arbiter and controller side.
interface mpmc11_fifo_issue_if #(
   parameter int WID = 128
);
   logic [WID-1:0] fifo_dout;
   logic           fifo_dv;
   logic           fifo_rd_rst_busy;
   logic           fifo_rd;
   logic           req_valid;
   logic [WID-1:0] req_data;
   logic           req_ready;
   logic           rty;
   logic           flush;
   logic           err_drop;
   logic [15:0]    issued_cnt;
   logic           busy;

   modport master (
      input  fifo_dout, fifo_dv, fifo_rd_rst_busy,
      input  req_ready, rty, flush,
      output fifo_rd, req_valid, req_data,
      output err_drop, issued_cnt, busy
   );

   modport slave (
      output fifo_dout, fifo_dv, fifo_rd_rst_busy,
      output req_ready, rty, flush,
      input  fifo_rd, req_valid, req_data,
      input  err_drop, issued_cnt, busy
   );
endinterface

// File: rtl/mpmc11_fifo_issue.sv
// Pops FWFT entries from the mpmc11 port FIFO into one hold register and
// presents them to the arbiter with retry back-off and bounded retries.
// Ports: clk, rst_n (async, active-low), bus (mpmc11_fifo_issue_if.master).
module mpmc11_fifo_issue #(
   parameter int WID       = 128,
   parameter int MAX_RETRY = 7,
   parameter int BACKOFF   = 4
) (
   input logic clk,
   input logic rst_n,
   mpmc11_fifo_issue_if.master bus
);
   typedef enum logic [1:0] {
      IDLE,
      PRESENT,
      RETRY_WAIT
   } state_t;

   localparam logic [3:0] RETRY_LAST = 4'(MAX_RETRY - 1);
   localparam logic [7:0] WAIT_INIT  = 8'(BACKOFF - 1);

   state_t         state, state_nx;
   logic [WID-1:0] data, data_nx;
   logic [3:0]     retry_cnt, retry_nx;
   logic [7:0]     backoff_cnt, backoff_nx;
   logic           drop, drop_nx;
   logic [15:0]    cnt, cnt_nx;
   logic           pop;

   // rst_n is folded in so no pop is issued while reset is held.
   assign pop = (state == IDLE) & bus.fifo_dv &
                ~bus.fifo_rd_rst_busy & ~bus.flush & rst_n;

   always_comb begin
      state_nx   = state;
      data_nx    = data;
      retry_nx   = retry_cnt;
      backoff_nx = backoff_cnt;
      drop_nx    = 1'b0;
      cnt_nx     = cnt;
      unique case (state)
         IDLE: begin
            if (pop) begin
               data_nx  = bus.fifo_dout;
               retry_nx = '0;
               state_nx = PRESENT;
            end
         end
         PRESENT: begin
            // flush wins over any handshake in the same cycle
            if (bus.flush) begin
               state_nx = IDLE;
            end else if (bus.req_ready) begin
               if (!bus.rty) begin
                  cnt_nx   = cnt + 16'd1;
                  state_nx = IDLE;
               end else if (retry_cnt < RETRY_LAST) begin
                  retry_nx   = retry_cnt + 4'd1;
                  backoff_nx = WAIT_INIT;
                  state_nx   = RETRY_WAIT;
               end else begin
                  drop_nx  = 1'b1;
                  state_nx = IDLE;
               end
            end
         end
         RETRY_WAIT: begin
            if (bus.flush) begin
               state_nx = IDLE;
            end else if (backoff_cnt == 8'd0) begin
               state_nx = PRESENT;
            end else begin
               backoff_nx = backoff_cnt - 8'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         data        <= '0;
         retry_cnt   <= '0;
         backoff_cnt <= '0;
         drop        <= 1'b0;
         cnt         <= '0;
      end else begin
         state       <= state_nx;
         data        <= data_nx;
         retry_cnt   <= retry_nx;
         backoff_cnt <= backoff_nx;
         drop        <= drop_nx;
         cnt         <= cnt_nx;
      end
   end

   assign bus.fifo_rd    = pop;
   assign bus.req_valid  = (state == PRESENT);
   assign bus.req_data   = data;
   assign bus.err_drop   = drop;
   assign bus.issued_cnt = cnt;
   assign bus.busy       = (state != IDLE);
endmodule
